// File: rtl/branch_predictor_pkg.sv
// bp_pkg: shared widths, counter encodings and table entry layout for the branch predictor.
package bp_pkg;
    localparam int BP_PC_W    = 9;
    localparam int BP_ENTRIES = 16;
    localparam int BP_CNT_W   = 2;
    localparam int BP_STAT_W  = 16;
    localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
    localparam int BP_TAG_W   = BP_PC_W - BP_IDX_W - 2;
    localparam logic [1:0] CNT_WEAK_NT  = 2'b01;
    localparam logic [1:0] CNT_WEAK_T   = 2'b10;
    localparam logic [1:0] CNT_STRONG_T = 2'b11;
    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_PC_W-1:0]  target;
        logic [BP_CNT_W-1:0] cnt;
    } bp_entry_t;
endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup, EX training and statistics signals of the predictor.
interface branch_predictor_if #(parameter int PC_W = 9, parameter int STAT_W = 16);
    logic [PC_W-1:0]   lookup_pc;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_target;
    logic              upd_en;
    logic [PC_W-1:0]   upd_pc;
    logic              upd_taken;
    logic              upd_uncond;
    logic [PC_W-1:0]   upd_target;
    logic              upd_mispredict;
    logic [STAT_W-1:0] stat_upd_cnt;
    logic [STAT_W-1:0] stat_mispred_cnt;
    modport master (
        output lookup_pc, upd_en, upd_pc, upd_taken, upd_uncond, upd_target, upd_mispredict,
        input  pred_taken, pred_target, stat_upd_cnt, stat_mispred_cnt
    );
    modport slave (
        input  lookup_pc, upd_en, upd_pc, upd_taken, upd_uncond, upd_target, upd_mispredict,
        output pred_taken, pred_target, stat_upd_cnt, stat_mispred_cnt
    );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// bp_sat_counter: next-value logic for a W-bit saturating counter (set forces all-ones).
module bp_sat_counter #(parameter int W = 2) (
    input  logic [W-1:0] d,
    input  logic         inc,
    input  logic         dec,
    input  logic         set,
    output logic [W-1:0] q
);
    assign q = set ? '1 : (inc && !(&d)) ? d + W'(1) : (dec && (|d)) ? d - W'(1) : d;
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB + 2-bit BHT, zero-latency lookup, one EX update per cycle.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int PC_W    = BP_PC_W,
    parameter int ENTRIES = BP_ENTRIES,
    parameter int CNT_W   = BP_CNT_W,
    parameter int STAT_W  = BP_STAT_W
) (
    input logic clk,
    input logic reset,
    branch_predictor_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;
    localparam logic [CNT_W-1:0] WEAK_NT = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] WEAK_T  = {1'b1, {(CNT_W-1){1'b0}}};
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
        logic [CNT_W-1:0] cnt;
    } entry_t;
    entry_t            table_q [ENTRIES];
    logic [IDX_W-1:0]  l_idx, u_idx;
    logic [TAG_W-1:0]  l_tag, u_tag;
    entry_t            l_e, u_e, w_e;
    logic              l_hit, u_hit, u_take, wr;
    logic [CNT_W-1:0]  u_cnt;
    logic [STAT_W-1:0] upd_q, mis_q, upd_d, mis_d;
    logic              unused_bits;
    assign unused_bits = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};
    assign l_idx = bus.lookup_pc[IDX_W+1:2];
    assign l_tag = bus.lookup_pc[PC_W-1:IDX_W+2];
    assign u_idx = bus.upd_pc[IDX_W+1:2];
    assign u_tag = bus.upd_pc[PC_W-1:IDX_W+2];
    assign l_e   = table_q[l_idx];
    assign u_e   = table_q[u_idx];
    assign l_hit = l_e.valid && l_e.tag == l_tag;
    assign u_hit = u_e.valid && u_e.tag == u_tag;
    // prediction is forced off while reset is held so the stale table never leaks out
    assign bus.pred_taken  = !reset && l_hit && l_e.cnt[CNT_W-1];
    assign bus.pred_target = bus.pred_taken ? l_e.target : bus.lookup_pc + PC_W'(4);
    assign u_take = bus.upd_taken || bus.upd_uncond;
    assign wr     = bus.upd_en && (u_hit || u_take);
    bp_sat_counter #(.W(CNT_W)) u_bht (
        .d(u_e.cnt), .inc(bus.upd_taken), .dec(!bus.upd_taken), .set(bus.upd_uncond), .q(u_cnt)
    );
    always_comb begin
        w_e.valid  = 1'b1;
        w_e.tag    = u_tag;
        w_e.target = u_take ? bus.upd_target : u_e.target;
        w_e.cnt    = u_hit ? u_cnt : bus.upd_uncond ? '1 : WEAK_T;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i].valid <= 1'b0;
                table_q[i].cnt   <= WEAK_NT;
            end
        end else if (wr) begin
            table_q[u_idx] <= w_e;
        end
    end
    bp_sat_counter #(.W(STAT_W)) u_stat_upd (
        .d(upd_q), .inc(bus.upd_en), .dec(1'b0), .set(1'b0), .q(upd_d)
    );
    bp_sat_counter #(.W(STAT_W)) u_stat_mis (
        .d(mis_q), .inc(bus.upd_en && bus.upd_mispredict), .dec(1'b0), .set(1'b0), .q(mis_d)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            upd_q <= '0;
            mis_q <= '0;
        end else begin
            upd_q <= upd_d;
            mis_q <= mis_d;
        end
    end
    assign bus.stat_upd_cnt     = upd_q;
    assign bus.stat_mispred_cnt = mis_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: table-driven vectors with an expected-result queue, plus a stat saturation sequence.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    branch_predictor_if #(.PC_W(9), .STAT_W(4)) bus ();
    branch_predictor #(.PC_W(9), .ENTRIES(16), .CNT_W(2), .STAT_W(4)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    typedef struct {
        logic rst, ue;
        logic [8:0] upc;
        logic ut, uu;
        logic [8:0] utgt;
        logic um;
        logic [8:0] lpc;
        logic etk;
        logic [8:0] etgt;
        logic [3:0] esu, esm;
    } vec_t;
    typedef struct {
        logic etk;
        logic [8:0] etgt;
        logic [3:0] esu, esm;
    } exp_t;
    vec_t vt [30];
    exp_t sb [$];
    int n_vec = 0;
    int n_fail = 0;
    function automatic vec_t mk(logic rst, logic ue, logic [8:0] upc, logic ut, logic uu,
                                logic [8:0] utgt, logic um, logic [8:0] lpc, logic etk,
                                logic [8:0] etgt, logic [3:0] esu, logic [3:0] esm);
        vec_t v;
        v.rst = rst; v.ue = ue; v.upc = upc; v.ut = ut; v.uu = uu; v.utgt = utgt; v.um = um;
        v.lpc = lpc; v.etk = etk; v.etgt = etgt; v.esu = esu; v.esm = esm;
        return v;
    endfunction
    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask
    task automatic drive(input vec_t v);
        reset              = v.rst;
        bus.upd_en         = v.ue;
        bus.upd_pc         = v.upc;
        bus.upd_taken      = v.ut;
        bus.upd_uncond     = v.uu;
        bus.upd_target     = v.utgt;
        bus.upd_mispredict = v.um;
        bus.lookup_pc      = v.lpc;
    endtask
    task automatic compare_head(input int idx);
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", idx, 16'd1, 16'd0);
            return;
        end
        e = sb.pop_front();
        check("pred_taken", idx, 16'(bus.pred_taken), 16'(e.etk));
        check("pred_target", idx, 16'(bus.pred_target), 16'(e.etgt));
        check("stat_upd_cnt", idx, 16'(bus.stat_upd_cnt), 16'(e.esu));
        check("stat_mispred_cnt", idx, 16'(bus.stat_mispred_cnt), 16'(e.esm));
    endtask
    initial begin
        //        rst ue  upc     ut  uu  utgt    um  lpc     etk etgt    su  sm
        vt[0]  = mk(1, 1, 9'h040, 1, 0, 9'h010, 1, 9'h040, 0, 9'h044, 0, 0);
        vt[1]  = mk(0, 0, 9'h000, 0, 0, 9'h000, 0, 9'h040, 0, 9'h044, 0, 0);
        vt[2]  = mk(0, 1, 9'h040, 1, 0, 9'h010, 1, 9'h040, 0, 9'h044, 0, 0);
        vt[3]  = mk(0, 0, 9'h000, 0, 0, 9'h000, 0, 9'h040, 1, 9'h010, 1, 1);
        vt[4]  = mk(0, 1, 9'h040, 0, 0, 9'h000, 1, 9'h040, 1, 9'h010, 1, 1);
        vt[5]  = mk(0, 1, 9'h040, 0, 0, 9'h000, 0, 9'h040, 0, 9'h044, 2, 2);
        vt[6]  = mk(0, 1, 9'h040, 1, 0, 9'h010, 0, 9'h040, 0, 9'h044, 3, 2);
        vt[7]  = mk(0, 1, 9'h040, 1, 0, 9'h020, 0, 9'h040, 0, 9'h044, 4, 2);
        vt[8]  = mk(0, 1, 9'h040, 1, 0, 9'h010, 0, 9'h040, 1, 9'h020, 5, 2);
        vt[9]  = mk(0, 0, 9'h000, 0, 0, 9'h000, 0, 9'h040, 1, 9'h010, 6, 2);
        vt[10] = mk(0, 1, 9'h040, 1, 0, 9'h010, 0, 9'h040, 1, 9'h010, 6, 2);
        vt[11] = mk(0, 1, 9'h040, 0, 0, 9'h000, 0, 9'h040, 1, 9'h010, 7, 2);
        vt[12] = mk(0, 0, 9'h000, 0, 0, 9'h000, 0, 9'h040, 1, 9'h010, 8, 2);
        vt[13] = mk(0, 0, 9'h000, 0, 0, 9'h000, 0, 9'h080, 0, 9'h084, 8, 2);
        vt[14] = mk(0, 1, 9'h080, 1, 0, 9'h100, 0, 9'h080, 0, 9'h084, 8, 2);
        vt[15] = mk(0, 0, 9'h000, 0, 0, 9'h000, 0, 9'h080, 1, 9'h100, 9, 2);
        vt[16] = mk(0, 0, 9'h000, 0, 0, 9'h000, 0, 9'h040, 0, 9'h044, 9, 2);
        vt[17] = mk(0, 1, 9'h0C0, 0, 0, 9'h000, 0, 9'h080, 1, 9'h100, 9, 2);
        vt[18] = mk(0, 0, 9'h000, 0, 0, 9'h000, 0, 9'h080, 1, 9'h100, 10, 2);
        vt[19] = mk(0, 0, 9'h000, 0, 0, 9'h000, 0, 9'h1FC, 0, 9'h000, 10, 2);
        vt[20] = mk(0, 1, 9'h1FC, 1, 1, 9'h0A4, 1, 9'h1FC, 0, 9'h000, 10, 2);
        vt[21] = mk(0, 1, 9'h1FC, 0, 0, 9'h000, 0, 9'h1FC, 1, 9'h0A4, 11, 3);
        vt[22] = mk(0, 0, 9'h000, 0, 0, 9'h000, 0, 9'h1FC, 1, 9'h0A4, 12, 3);
        vt[23] = mk(0, 0, 9'h000, 0, 0, 9'h000, 1, 9'h1FC, 1, 9'h0A4, 12, 3);
        vt[24] = mk(0, 0, 9'h000, 0, 0, 9'h000, 0, 9'h1FC, 1, 9'h0A4, 12, 3);
        vt[25] = mk(0, 1, 9'h082, 1, 0, 9'h0C8, 0, 9'h081, 1, 9'h100, 12, 3);
        vt[26] = mk(0, 0, 9'h000, 0, 0, 9'h000, 0, 9'h080, 1, 9'h0C8, 13, 3);
        vt[27] = mk(1, 1, 9'h040, 1, 0, 9'h010, 1, 9'h080, 0, 9'h084, 13, 3);
        vt[28] = mk(0, 0, 9'h000, 0, 0, 9'h000, 0, 9'h080, 0, 9'h084, 0, 0);
        vt[29] = mk(0, 0, 9'h000, 0, 0, 9'h000, 0, 9'h1FC, 0, 9'h000, 0, 0);
        drive(mk(1, 0, 0, 0, 0, 0, 0, 9'h040, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            drive(vt[i]);
            sb.push_back('{vt[i].etk, vt[i].etgt, vt[i].esu, vt[i].esm});
            #2;
            compare_head(i);
        end
        // twenty mispredicted updates must saturate both 4-bit stats at 15
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(mk(0, 1, 9'h100, 1, 0, 9'h0F0, 1, 9'h000, 0, 0, 0, 0));
        end
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 9'h100, 0, 0, 0, 0));
        sb.push_back('{1'b1, 9'h0F0, 4'd15, 4'd15});
        #2;
        compare_head(30);
        @(negedge clk);
        drive(mk(0, 1, 9'h100, 0, 0, 0, 1, 9'h100, 0, 0, 0, 0));
        sb.push_back('{1'b1, 9'h0F0, 4'd15, 4'd15});
        #2;
        compare_head(31);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 9'h100, 0, 0, 0, 0));
        sb.push_back('{1'b1, 9'h0F0, 4'd15, 4'd15});
        #2;
        compare_head(32);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
